mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the RISC-V single-cycle core, replacing the fixed 4-switch / 4-LED / 2-digit decode. It sits on the data-memory bus beside data RAM and claims the window at BASE_ADDR. It provides:
- synchronised and debounced switch inputs;
- sticky write-1-to-clear switch-change flags with an interrupt line;
- an LED register with an optional blink mode;
- NUM_DIGITS hex-to-7-segment digit registers with a global blank control.

## Interface
Parameters:
- BASE_ADDR, 32'h00001000: window base; window size 0x50 bytes.
- SW_WIDTH, 4: switch inputs, 1..32.
- LED_WIDTH, 4: LED outputs, 1..32.
- NUM_DIGITS, 2: 7-segment digits, 1..14.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a switch change is accepted; must be >= 1.
- BLINK_DIV, 8: cycles per blink half-period; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the core (DataAdr); addr[1:0] ignored.
- wdata  in  32  store data (WriteData).
- we  in  1  store strobe (MemWrite).
- sel  out  1  combinational; 1 when addr is in [BASE_ADDR, BASE_ADDR+0x50).
- rdata  out  32  combinational read data; 0 when sel=0 or the offset is unmapped.
- sw_in  in  SW_WIDTH  raw asynchronous switch inputs.
- leds  out  LED_WIDTH  LED drive.
- seg  out  7*NUM_DIGITS  digit k occupies seg[7k+6:7k]; bit order {g,f,e,d,c,b,a}; active-low.
- irq  out  1  registered; equals |(EDGE & IRQ_EN).

## Operation
Register map (offsets from BASE_ADDR):
- 0x00 SW: RO; debounced switch state, zero-extended.
- 0x04 LED: RW; bits [LED_WIDTH-1:0].
- 0x08+4k SEGk: RW for k < NUM_DIGITS; 4-bit hex nibble in [3:0].
- 0x40 EDGE: read returns the sticky change flags; writing 1 to a bit clears it.
- 0x44 CTRL: RW; bit0 seg_blank, bit1 led_blink.
- 0x48 IRQ_EN: RW; bits [SW_WIDTH-1:0].

General access rules:
- A write takes effect on the rising edge where sel & we = 1.
- Writes to SW, to unmapped offsets, and to unimplemented bits are ignored. Unimplemented bits read as 0.

Switch path, per bit:
- 2-flop synchroniser feeding sync2.
- A counter increments each cycle that sync2 ≠ db and clears whenever sync2 = db.
- When sync2 ≠ db and the counter equals DEBOUNCE_CYCLES-1, db takes sync2, the counter clears, and the EDGE bit sets on that same edge.
- If a W1C clear and a set hit the same EDGE bit in one cycle, the set wins.

Segments:
- With seg_blank=1, every digit drives 7'b1111111.
- Otherwise each digit shows its nibble decoded as follows:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110

LEDs:
- With led_blink=0, leds = LED, the blink counter is held at 0, and phase is held at 1.
- With led_blink=1, the counter counts 0..BLINK_DIV-1 and wraps. phase toggles on each wrap. leds = LED & {LED_WIDTH{phase}}.

## Timing
Reset (reset=0, async):
- LED=0, SEGk=0, EDGE=0, CTRL=1 (blanked), IRQ_EN=0.
- Synchronisers, db and all counters = 0; phase=1.
- Outputs: leds=0, seg all 1s, irq=0.

Read path:
- rdata is combinational, with zero added latency, so a load completes in the core's single cycle.

Write path:
- LED, SEGk and CTRL writes show on leds/seg one cycle later, as registered-state-driven combinational outputs.

irq:
- Registered; asserts one edge after the edge on which an enabled EDGE bit sets.

Switch latency:
- A sw_in level captured at edge E0, then held stable, appears in SW and EDGE after edge E0+DEBOUNCE_CYCLES+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 leaves db unchanged and sets no flag.

Blink:
- First leds drop occurs BLINK_DIV cycles after the edge that sets led_blink.
- Clearing led_blink restores leds=LED on the next cycle.

Reset mid-operation:
- All state returns to reset values immediately. Pending debounce counts are discarded.

## Test plan
- Reset then idle, default parameters: leds=4'b0000, seg=14'h3FFF, irq=0; read 0x1000 returns 0.
- Store 0x5 to 0x1004; store 0x3 to 0x1008 and 0xA to 0x100C; store 0 to 0x1044 → leds=4'b0101, seg[6:0]=7'b0110000, seg[13:7]=7'b0001000.
- With IRQ_EN=4'b1111, drive sw_in=4'b1010 at edge E0 → SW=0xA and EDGE=0xA after edge E0+5, irq=1 after edge E0+6. Store 0x2 to 0x1040 → EDGE=0x8, irq stays 1. Store 0x8 to 0x1040 → irq=0 on the next edge.
- Pulse sw_in[0] high for 3 cycles (DEBOUNCE_CYCLES=4) → SW[0] stays 0 and EDGE[0] stays 0.
- Hold sw_in[1] changed while storing 1 to EDGE[1] on exactly the set edge → EDGE[1]=1 (set wins).
- Set LED=0xF and CTRL=2 → leds alternates 0xF for 8 cycles and 0x0 for 8 cycles. Assert reset mid-blink → leds=0 and seg blanked immediately. Read of 0x104C returns 0.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O window for the single-cycle RISC-V core.
// Provides debounced switches with sticky change flags and an interrupt,
// an LED register with optional blink, and hex-decoded 7-segment digits.
module mmio_io_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          SW_WIDTH        = 4,
    parameter int          LED_WIDTH       = 4,
    parameter int          NUM_DIGITS      = 2,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          BLINK_DIV       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic                    we,
    output logic                    sel,
    output logic [31:0]             rdata,
    input  logic [SW_WIDTH-1:0]     sw_in,
    output logic [LED_WIDTH-1:0]    leds,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    irq
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

    // Word index within the window (offset / 4).
    localparam logic [4:0] IDX_SW     = 5'd0;
    localparam logic [4:0] IDX_LED    = 5'd1;
    localparam logic [4:0] IDX_SEG0   = 5'd2;
    localparam logic [4:0] IDX_EDGE   = 5'd16;
    localparam logic [4:0] IDX_CTRL   = 5'd17;
    localparam logic [4:0] IDX_IRQ_EN = 5'd18;

    logic [31:0]         w_off;
    logic [4:0]          w_idx;
    logic                w_wr;
    logic [SW_WIDTH-1:0] w_db_set;
    logic [SW_WIDTH-1:0] w_w1c;
    logic                w_unused_wdata;

    logic [SW_WIDTH-1:0]  r_sync1;
    logic [SW_WIDTH-1:0]  r_sync2;
    logic [SW_WIDTH-1:0]  r_db;
    logic [DB_W-1:0]      r_db_cnt [SW_WIDTH];
    logic [SW_WIDTH-1:0]  r_edge;
    logic [SW_WIDTH-1:0]  r_irq_en;
    logic                 r_irq;
    logic [LED_WIDTH-1:0] r_led;
    logic [1:0]           r_ctrl;      // [0] seg_blank, [1] led_blink
    logic [3:0]           r_seg [NUM_DIGITS];
    logic [BL_W-1:0]      r_blink_cnt;
    logic                 r_phase;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // Address decode; subtraction wraps, so the lower-bound test is explicit.
    assign w_off = addr - BASE_ADDR;
    assign w_idx = w_off[6:2];
    assign sel   = (addr >= BASE_ADDR) && (w_off < 32'h50);
    assign w_wr  = sel & we;
    assign w_w1c = (w_wr && (w_idx == IDX_EDGE)) ? wdata[SW_WIDTH-1:0] : '0;
    assign w_unused_wdata = ^wdata;

    // Per-bit debounce acceptance: the stable count has reached its limit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_db_set = '0;
        for (int b = 0; b < SW_WIDTH; b++) begin
            w_db_set[b] = (r_sync2[b] != r_db[b]) && (r_db_cnt[b] == DB_LAST);
        end
    end

    // Two-flop synchroniser followed by a per-bit stability counter.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int b = 0; b < SW_WIDTH; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            for (int b = 0; b < SW_WIDTH; b++) begin
                if (r_sync2[b] == r_db[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (w_db_set[b]) begin
                    r_db[b]     <= r_sync2[b];
                    r_db_cnt[b] <= '0;
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // Sticky change flags (a set beats a same-cycle clear) and registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_db_set;
            r_irq  <= |(r_edge & r_irq_en);
        end
    end

    // Software-writable registers: LED, CTRL, IRQ_EN and the digit nibbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led    <= '0;
            r_ctrl   <= 2'b01;
            r_irq_en <= '0;
            // NOTE: the digit array is a handful of flops, not a RAM, so it is reset like any register.
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_seg[k] <= 4'h0;
            end
        end else if (w_wr) begin
            case (w_idx)
                IDX_LED:    r_led    <= wdata[LED_WIDTH-1:0];
                IDX_CTRL:   r_ctrl   <= wdata[1:0];
                IDX_IRQ_EN: r_irq_en <= wdata[SW_WIDTH-1:0];
                default: ;
            endcase
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_idx == 5'(IDX_SEG0 + k)) begin
                    r_seg[k] <= wdata[3:0];
                end
            end
        end
    end

    // Blink timebase: idle at count 0 / phase 1 while blink is off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!r_ctrl[1]) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BL_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
    end

    // LED and digit drive; blink gating follows CTRL directly so turning it off is immediate.
    always_comb begin
        leds = r_ctrl[1] ? (r_led & {LED_WIDTH{r_phase}}) : r_led;
        seg  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg[7*k +: 7] = r_ctrl[0] ? 7'b1111111 : hex_to_seg(r_seg[k]);
        end
    end

    // Combinational read mux; unmapped offsets and unimplemented bits read 0.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (w_idx)
                IDX_SW:     rdata = 32'(r_db);
                IDX_LED:    rdata = 32'(r_led);
                IDX_EDGE:   rdata = 32'(r_edge);
                IDX_CTRL:   rdata = {30'b0, r_ctrl};
                IDX_IRQ_EN: rdata = 32'(r_irq_en);
                default: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (w_idx == 5'(IDX_SEG0 + k)) begin
                            rdata = {28'b0, r_seg[k]};
                        end
                    end
                end
            endcase
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed stimulus for mmio_io_ctrl with a cycle-level
// behavioural model checked on every falling edge plus literal spot checks.
module tb_mmio_io_ctrl;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int SW_W  = 4;
    localparam int LED_W = 4;
    localparam int ND    = 2;
    localparam int DB    = 4;
    localparam int BD    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              we;
    logic [SW_W-1:0]   sw_in;
    logic              sel;
    logic [31:0]       rdata;
    logic [LED_W-1:0]  leds;
    logic [7*ND-1:0]   seg;
    logic              irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic run_cmp = 1'b0;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .BASE_ADDR(BASE), .SW_WIDTH(SW_W), .LED_WIDTH(LED_W),
        .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(rst_n), .addr(addr), .wdata(wdata), .we(we),
        .sel(sel), .rdata(rdata), .sw_in(sw_in), .leds(leds), .seg(seg), .irq(irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [LED_W-1:0] m_led;
    logic [3:0]       m_seg [ND];
    logic [SW_W-1:0]  m_edge, m_irq_en, m_db, m_s1, m_s2;
    logic [1:0]       m_ctrl;
    logic             m_irq;
    int               m_age;           // edges spent with blink enabled
    logic [SW_W-1:0]  m_hist [$];      // last DB synchronised samples

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h50);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] off;
        if (!in_window(a)) return 32'h0;
        off = (a - BASE) & ~32'h3;
        if (off == 32'h00) return 32'(m_db);
        if (off == 32'h04) return 32'(m_led);
        if (off == 32'h40) return 32'(m_edge);
        if (off == 32'h44) return 32'(m_ctrl);
        if (off == 32'h48) return 32'(m_irq_en);
        if (off >= 32'h08 && off < 32'(8 + 4 * ND)) return 32'(m_seg[(off - 8) / 4]);
        return 32'h0;
    endfunction

    function automatic logic [LED_W-1:0] exp_leds();
        if (m_ctrl[1] && ((m_age / BD) % 2 == 1)) return '0;
        return m_led;
    endfunction

    function automatic logic [7*ND-1:0] exp_seg();
        logic [7*ND-1:0] s;
        for (int k = 0; k < ND; k++) s[7*k +: 7] = m_ctrl[0] ? 7'h7F : seg_tab[m_seg[k]];
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        logic [SW_W-1:0] v_set, v_w1c;
        logic [31:0]     v_off;
        logic            v_wr, v_all;
        if (!rst_n) begin
            m_led = '0; m_edge = '0; m_irq_en = '0; m_db = '0;
            m_s1 = '0; m_s2 = '0; m_ctrl = 2'b01; m_irq = 1'b0; m_age = 0;
            for (int k = 0; k < ND; k++) m_seg[k] = 4'h0;
            m_hist.delete();
        end else begin
            v_wr  = we && in_window(addr);
            v_off = (addr - BASE) & ~32'h3;
            // A switch bit flips once DB consecutive synchronised samples disagree with it.
            m_hist.push_back(m_s2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            v_set = '0;
            if (m_hist.size() == DB) begin
                for (int b = 0; b < SW_W; b++) begin
                    v_all = 1'b1;
                    for (int i = 0; i < m_hist.size(); i++)
                        if (m_hist[i][b] == m_db[b]) v_all = 1'b0;
                    v_set[b] = v_all;
                end
            end
            m_db   = m_db ^ v_set;
            m_irq  = |(m_edge & m_irq_en);
            v_w1c  = (v_wr && v_off == 32'h40) ? wdata[SW_W-1:0] : '0;
            m_edge = (m_edge & ~v_w1c) | v_set;
            if (m_ctrl[1]) m_age++; else m_age = 0;
            if (v_wr) begin
                if (v_off == 32'h04) m_led = wdata[LED_W-1:0];
                if (v_off == 32'h44) m_ctrl = wdata[1:0];
                if (v_off == 32'h48) m_irq_en = wdata[SW_W-1:0];
                if (v_off >= 32'h08 && v_off < 32'(8 + 4 * ND)) m_seg[(v_off - 8) / 4] = wdata[3:0];
            end
            m_s2 = m_s1;
            m_s1 = sw_in;
        end
    end

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_leds",  64'(leds),  64'(exp_leds()));
            check("cmp_seg",   64'(seg),   64'(exp_seg()));
            check("cmp_irq",   64'(irq),   64'(m_irq));
            check("cmp_sel",   64'(sel),   64'(in_window(addr)));
            check("cmp_rdata", 64'(rdata), 64'(exp_rdata(addr)));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; addr = 32'h0;
    endtask

    task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a; we = 1'b0;
        #1;
        check(name, 64'(rdata), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; sw_in = '0;
        #1 rst_n = 1'b0;
        run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        check("rst_leds", 64'(leds), 64'h0);
        check("rst_seg",  64'(seg),  64'h3FFF);
        check("rst_irq",  64'(irq),  64'h0);
        read_check(32'h1000, 32'h0, "rst_sw");
        read_check(32'h1044, 32'h1, "rst_ctrl");
        tick();

        // LED / digit writes, unblank.
        bus_write(32'h1004, 32'h5);
        bus_write(32'h1008, 32'h3);
        bus_write(32'h100C, 32'hA);
        bus_write(32'h1044, 32'h0);
        check("leds_0101", 64'(leds), 64'b0101);
        check("seg_dig0",  64'(seg[6:0]),  64'b0110000);
        check("seg_dig1",  64'(seg[13:7]), 64'b0001000);

        // Ignored writes and unimplemented bits.
        bus_write(32'h1000, 32'hFFFF_FFFF);
        read_check(32'h1000, 32'h0, "sw_read_only");
        bus_write(32'h1010, 32'h7);
        read_check(32'h1010, 32'h0, "seg2_unmapped");
        bus_write(32'h1004, 32'hFFFF_FFF5);
        read_check(32'h1004, 32'h5, "led_mask");
        read_check(32'h1050, 32'h0, "above_window");
        check("above_window_sel", 64'(sel), 64'h0);

        // Switch debounce latency and irq.
        bus_write(32'h1048, 32'hF);
        sw_in = 4'b1010;
        @(posedge clk);                         // E0
        repeat (4) @(posedge clk);
        #1;
        read_check(32'h1000, 32'h0, "sw_at_e0p4");
        @(posedge clk); #1;                     // after E0+5
        read_check(32'h1000, 32'hA, "sw_at_e0p5");
        read_check(32'h1040, 32'hA, "edge_at_e0p5");
        check("irq_at_e0p5", 64'(irq), 64'h0);
        @(posedge clk); #1;
        check("irq_at_e0p6", 64'(irq), 64'h1);
        bus_write(32'h1040, 32'h2);
        read_check(32'h1040, 32'h8, "edge_w1c");
        check("irq_held", 64'(irq), 64'h1);
        bus_write(32'h1040, 32'h8);
        check("irq_lag", 64'(irq), 64'h1);
        tick();
        check("irq_clear", 64'(irq), 64'h0);

        // Three-cycle glitch on sw_in[0] must be rejected.
        sw_in = 4'b1011;
        repeat (3) @(posedge clk);
        #1 sw_in = 4'b1010;
        repeat (10) tick();
        read_check(32'h1000, 32'hA, "glitch_sw");
        read_check(32'h1040, 32'h0, "glitch_edge");
        check("glitch_irq", 64'(irq), 64'h0);

        // Clear and set of EDGE[1] on the same edge: set wins.
        sw_in = 4'b1000;
        @(posedge clk);                         // E0
        repeat (4) @(posedge clk);
        #1;
        bus_write(32'h1040, 32'h2);             // lands on E0+5
        read_check(32'h1040, 32'h2, "set_wins");
        read_check(32'h1000, 32'h8, "sw_1000");
        bus_write(32'h1040, 32'hF);
        tick();
        check("irq_after_clear", 64'(irq), 64'h0);

        // Blink: 8 cycles on, 8 off.
        bus_write(32'h1004, 32'hF);
        bus_write(32'h1044, 32'h2);
        for (int m = 0; m < 12; m++) begin
            check("blink_pattern", 64'(leds), ((m / 8) % 2 == 0) ? 64'hF : 64'h0);
            tick();
        end
        check("blink_low", 64'(leds), 64'h0);
        bus_write(32'h1044, 32'h0);
        check("blink_off", 64'(leds), 64'hF);
        bus_write(32'h1044, 32'h2);
        repeat (10) tick();
        check("blink_low2", 64'(leds), 64'h0);

        // Asynchronous reset mid-blink.
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_leds", 64'(leds), 64'h0);
        check("mid_rst_seg",  64'(seg),  64'h3FFF);
        check("mid_rst_irq",  64'(irq),  64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        read_check(32'h104C, 32'h0, "unmapped_104c");
        check("sel_104c", 64'(sel), 64'h1);
        read_check(32'h1044, 32'h1, "ctrl_after_rst");
        tick();
        read_check(32'h1004, 32'h0, "led_after_rst");
        repeat (10) tick();
        read_check(32'h1000, 32'h8, "sw_resync");

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
